// File: rtl/bp_update_queue_pkg.sv
// Shared types for the branch-predictor update queue: core config, predictor
// metadata captured at prediction time, and the update word sent to the BHT.
package bp_update_queue_pkg;

    localparam int unsigned BP_VLEN               = 32;
    localparam int unsigned BP_GINDEX_W           = 10;
    localparam int unsigned BP_LINDEX_W           = 8;
    localparam int unsigned BP_UPDATE_QUEUE_DEPTH = 8;

    typedef struct packed {
        int unsigned VLEN;
    } bp_cfg_t;

    localparam bp_cfg_t BP_CFG_DEFAULT = '{VLEN: BP_VLEN};

    typedef struct packed {
        logic [BP_GINDEX_W-1:0] gindex;
        logic                   gbp_valid;
        logic                   gbp_taken;
        logic [BP_LINDEX_W-1:0] lindex;
        logic                   lbp_valid;
        logic                   lbp_taken;
    } bp_metadata_t;

    typedef struct packed {
        logic               valid;
        logic [BP_VLEN-1:0] pc;
        logic               taken;
        bp_metadata_t       metadata;
    } bp_bht_update_t;

endpackage

// File: rtl/bp_update_queue.sv
// In-order queue holding prediction metadata from branch issue until resolve,
// then emitting a registered one-cycle predictor update (or a mismatch pulse).
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter bp_cfg_t     CVA6Cfg       = BP_CFG_DEFAULT,
    parameter type         bp_metadata_t = bp_update_queue_pkg::bp_metadata_t,
    parameter type         bht_update_t  = bp_update_queue_pkg::bp_bht_update_t,
    parameter int unsigned DEPTH         = BP_UPDATE_QUEUE_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          debug_mode_i,
    input  logic                          push_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]       push_pc_i,
    input  bp_metadata_t                  push_metadata_i,
    output logic                          push_ready_o,
    input  logic                          resolve_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]       resolve_pc_i,
    input  logic                          resolve_taken_i,
    output bht_update_t                   bht_update_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          mismatch_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned VLEN = CVA6Cfg.VLEN;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        bp_metadata_t    metadata;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    bht_update_t     upd_q, upd_d;
    logic            mismatch_q, mismatch_d;

    logic            push_fire;
    logic            pop_fire;
    logic            pc_match;
    entry_t          head;

    assign push_ready_o = (count_q != CW'(DEPTH));
    assign push_fire    = push_valid_i && push_ready_o && !flush_i;
    assign pop_fire     = resolve_valid_i && (count_q != '0);
    assign head         = mem_q[rptr_q];
    assign pc_match     = (resolve_pc_i == head.pc);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        upd_d      = '0;
        mismatch_d = 1'b0;

        if (push_fire) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_fire) begin
            rptr_d = rptr_q + 1'b1;
            if (pc_match) begin
                upd_d.valid    = !debug_mode_i;
                upd_d.pc       = resolve_pc_i;
                upd_d.taken    = resolve_taken_i;
                upd_d.metadata = head.metadata;
            end else begin
                mismatch_d = 1'b1;
            end
        end
        if (push_fire && !pop_fire) begin
            count_d = count_q + 1'b1;
        end else if (pop_fire && !push_fire) begin
            count_d = count_q - 1'b1;
        end

        // The resolve in a flush cycle still reports; only the queue state is cleared.
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            upd_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            upd_q      <= upd_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Entry contents are don't-care until written; validity comes from count_q.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_q[wptr_q] <= '{pc: push_pc_i, metadata: push_metadata_i};
        end
    end

    assign bht_update_o = upd_q;
    assign mismatch_o   = mismatch_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: a reference queue model pushes expected
// update/mismatch results to a scoreboard that is checked one cycle later.
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                flush_i;
    logic                debug_mode_i;
    logic                push_valid_i;
    logic [BP_VLEN-1:0]  push_pc_i;
    bp_metadata_t        push_metadata_i;
    logic                push_ready_o;
    logic                resolve_valid_i;
    logic [BP_VLEN-1:0]  resolve_pc_i;
    logic                resolve_taken_i;
    bp_bht_update_t      bht_update_o;
    logic [CW-1:0]       count_o;
    logic                mismatch_o;

    bp_update_queue #(
        .CVA6Cfg       (BP_CFG_DEFAULT),
        .bp_metadata_t (bp_metadata_t),
        .bht_update_t  (bp_bht_update_t),
        .DEPTH         (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .push_valid_i    (push_valid_i),
        .push_pc_i       (push_pc_i),
        .push_metadata_i (push_metadata_i),
        .push_ready_o    (push_ready_o),
        .resolve_valid_i (resolve_valid_i),
        .resolve_pc_i    (resolve_pc_i),
        .resolve_taken_i (resolve_taken_i),
        .bht_update_o    (bht_update_o),
        .count_o         (count_o),
        .mismatch_o      (mismatch_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [BP_VLEN-1:0] pc;
        bp_metadata_t       meta;
    } ent_t;

    typedef struct packed {
        bp_bht_update_t upd;
        logic           mis;
    } exp_t;

    ent_t model_q[$];
    exp_t sb_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock of stimulus; the model predicts the registered outputs.
    task automatic step(input string tag,
                        input bit pv, input logic [BP_VLEN-1:0] ppc, input bp_metadata_t pm,
                        input bit rv, input logic [BP_VLEN-1:0] rpc, input bit rt,
                        input bit fl, input bit dbg);
        exp_t e;
        bit   ready;
        e     = '0;
        ready = (model_q.size() != DEPTH);
        if (rv && model_q.size() > 0) begin
            if (rpc == model_q[0].pc) begin
                e.upd.valid    = !dbg;
                e.upd.pc       = rpc;
                e.upd.taken    = rt;
                e.upd.metadata = model_q[0].meta;
            end else begin
                e.mis = 1'b1;
            end
            void'(model_q.pop_front());
        end
        if (pv && ready && !fl) model_q.push_back('{pc: ppc, meta: pm});
        if (fl) model_q.delete();
        sb_q.push_back(e);

        push_valid_i    = pv;
        push_pc_i       = ppc;
        push_metadata_i = pm;
        resolve_valid_i = rv;
        resolve_pc_i    = rpc;
        resolve_taken_i = rt;
        flush_i         = fl;
        debug_mode_i    = dbg;
        @(posedge clk_i);
        #1;
        push_valid_i    = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i         = 1'b0;
        debug_mode_i    = 1'b0;

        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'd0, 128'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_upd"},   128'(bht_update_o), 128'(e.upd));
            chk({tag, "_mis"},   128'(mismatch_o),   128'(e.mis));
            chk({tag, "_count"}, 128'(count_o),      128'(model_q.size()));
            chk({tag, "_ready"}, 128'(push_ready_o), 128'(model_q.size() != DEPTH));
        end
        $display("[%0t] %s push=%0b pc=%h res=%0b rpc=%h flush=%0b dbg=%0b -> upd.v=%0b mis=%0b cnt=%0d",
                 $time, tag, pv, ppc, rv, rpc, fl, dbg, bht_update_o.valid, mismatch_o, count_o);
    endtask

    function automatic bp_metadata_t mk_meta(input int g);
        bp_metadata_t m;
        m           = '0;
        m.gindex    = BP_GINDEX_W'(g);
        m.lindex    = BP_LINDEX_W'(g * 3 + 1);
        m.gbp_valid = 1'b1;
        m.gbp_taken = g[0];
        m.lbp_valid = g[1];
        m.lbp_taken = g[2];
        return m;
    endfunction

    initial begin
        bp_bht_update_t      ref_upd;
        bp_metadata_t        none;
        logic [BP_VLEN-1:0]  pc;
        none            = '0;
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        debug_mode_i    = 1'b0;
        push_valid_i    = 1'b0;
        push_pc_i       = '0;
        push_metadata_i = '0;
        resolve_valid_i = 1'b0;
        resolve_pc_i    = '0;
        resolve_taken_i = 1'b0;

        #12;
        chk("rst_count", 128'(count_o),      128'd0);
        chk("rst_ready", 128'(push_ready_o), 128'd1);
        chk("rst_upd",   128'(bht_update_o), 128'd0);
        chk("rst_mis",   128'(mismatch_o),   128'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic push then resolve with a known metadata word
        none.gindex = 10'd5;
        step("t1_push", 1, 32'h8000_0010, none, 0, '0, 0, 0, 0);
        none = '0;
        step("t1_res", 0, '0, none, 1, 32'h8000_0010, 1, 0, 0);
        ref_upd                 = '0;
        ref_upd.valid           = 1'b1;
        ref_upd.pc              = 32'h8000_0010;
        ref_upd.taken           = 1'b1;
        ref_upd.metadata.gindex = 10'd5;
        chk("t1_upd_const", 128'(bht_update_o), 128'(ref_upd));

        // Fill to full, then push+resolve on a full queue
        for (int i = 0; i < DEPTH; i++)
            step("t2_fill", 1, 32'h1000 + 32'(4 * i), mk_meta(i), 0, '0, 0, 0, 0);
        chk("t2_full_count", 128'(count_o),      128'd8);
        chk("t2_full_ready", 128'(push_ready_o), 128'd0);
        step("t2_ninth", 1, 32'h2000, mk_meta(99), 1, 32'h1000, 0, 0, 0);
        chk("t2_after_count", 128'(count_o), 128'd7);
        for (int i = 1; i < DEPTH; i++)
            step("t2_drain", 0, '0, none, 1, 32'h1000 + 32'(4 * i), i[0], 0, 0);

        // Flush with a simultaneous head resolve and a dropped push
        for (int i = 0; i < 3; i++)
            step("t3_push", 1, 32'h3000 + 32'(4 * i), mk_meta(20 + i), 0, '0, 0, 0, 0);
        step("t3_flush", 1, 32'h3100, mk_meta(40), 1, 32'h3000, 1, 1, 0);
        chk("t3_flush_upd_v", 128'(bht_update_o.valid), 128'd1);
        step("t3_late", 0, '0, none, 1, 32'h3004, 1, 0, 0);

        // PC mismatch
        step("t4_push", 1, 32'h100, mk_meta(7), 0, '0, 0, 0, 0);
        step("t4_res", 0, '0, none, 1, 32'h104, 1, 0, 0);
        chk("t4_mis_const", 128'(mismatch_o), 128'd1);

        // Debug mode suppresses the update but still pops
        step("t5_push", 1, 32'h200, mk_meta(9), 0, '0, 0, 0, 0);
        step("t5_res", 0, '0, none, 1, 32'h200, 1, 0, 1);
        chk("t5_valid_const", 128'(bht_update_o.valid), 128'd0);

        // Resolve on an empty queue
        step("t6_empty", 0, '0, none, 1, 32'h500, 1, 0, 0);

        // Wrap-around with simultaneous push/resolve keeps FIFO order
        for (int i = 0; i < 3; i++)
            step("t7_pre", 1, 32'h4000 + 32'(4 * i), mk_meta(50 + i), 0, '0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            pc = model_q[0].pc;
            step("t7_wrap", 1, 32'h4000 + 32'(4 * (i + 3)), mk_meta($urandom_range(0, 1023)),
                 1, pc, $urandom_range(0, 1), 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            pc = model_q[0].pc;
            step("t7_drain", 0, '0, none, 1, pc, 1, 0, 0);
        end

        // Asynchronous reset mid-operation
        step("t8_push", 1, 32'h600, mk_meta(1), 0, '0, 0, 0, 0);
        step("t8_push", 1, 32'h604, mk_meta(2), 0, '0, 0, 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        model_q.delete();
        chk("t8_rst_count", 128'(count_o),      128'd0);
        chk("t8_rst_ready", 128'(push_ready_o), 128'd1);
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step("t8_res", 0, '0, none, 1, 32'h600, 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
